traffic_phase_ctrl: RTL
=======================

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 Parameter NUM_ROADS, default 4, number of approach roads (legal 2..8); each road has 3 movements: L, S, R.
REQ-002 Parameter GREEN_TICKS, default 20, minimum green duration in ticks (legal 1..65535).
REQ-003 Parameter YELLOW_TICKS, default 5, yellow duration in ticks (legal 1..65535).
REQ-004 Parameter ALLRED_TICKS, default 2, all-red clearance duration in ticks (legal 1..65535).
REQ-005 Derived constant RW = max(1, clog2(NUM_ROADS)), road index width.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-008 tick_en  input  1  timebase strobe; timers advance only on cycles where tick_en=1.
REQ-009 demand  input  NUM_ROADS  bit k=1: vehicles waiting on road k.
REQ-010 emerg_req  input  1  emergency pre-emption request, level-sensitive.
REQ-011 emerg_road  input  RW  road to pre-empt to; values >= NUM_ROADS are ignored (treated as emerg_req=0).
REQ-012 red, yellow, green  output  3*NUM_ROADS each  lamp drives; bit 3k+0 = road k L, 3k+1 = S, 3k+2 = R.
REQ-013 phase_road  output  RW  road currently owning (or last owning) the right of way.
REQ-014 phase_state  output  2  00 ALL_RED, 01 GREEN, 10 YELLOW, 11 unused.
REQ-015 emerg_active  output  1  high while a pre-emption sequence is in progress or held.

Function
REQ-016 States: ALL_RED, GREEN, YELLOW; exactly one road (phase_road) may be non-red; all 3 movements of that road show the same lamp.
REQ-017 All outputs are registered; lamps, phase_state and phase_road change on the same edge as the state.
REQ-018 Per road k: exactly one of red/yellow/green is 1 for each movement in every cycle; roads != phase_road are red.
REQ-019 Timer loaded with D-1 on state entry (D = duration of the state entered); decrements on tick_en; state exits on a cycle with tick_en=1 and timer=0, so each state lasts exactly D ticks.
REQ-020 ALL_RED -> GREEN on expiry; phase_road takes next_road (latched at GREEN exit).
REQ-021 GREEN expiry: if any demand bit other than phase_road is 1, latch next_road = first road with demand searching phase_road+1, +2, ... cyclically, and go YELLOW; else stay GREEN (timer holds at 0, re-evaluated every tick).
REQ-022 YELLOW -> ALL_RED on expiry.
REQ-023 Pre-emption when emerg_req=1 and emerg_road valid: GREEN on emerg_road -> hold GREEN, ignore timer expiry; GREEN on another road -> go YELLOW next cycle regardless of timer, next_road = emerg_road; YELLOW/ALL_RED -> complete normally, next_road forced to emerg_road.
REQ-024 emerg_road changing during pre-emption redirects next_road if not yet in GREEN; in GREEN it triggers a fresh YELLOW sequence.
REQ-025 After emerg_req falls during emergency GREEN: timer reloads GREEN_TICKS-1, then REQ-021 applies; emerg_active falls on that reload edge.
REQ-026 Simultaneous tick expiry and emerg_req rise: pre-emption wins.
REQ-027 demand=0 everywhere: current road stays GREEN indefinitely.
REQ-028 tick_en=0: state and timer frozen; lamps hold.

Reset
REQ-029 On reset=0 (async): state ALL_RED, timer = ALLRED_TICKS-1, phase_road = NUM_ROADS-1, next_road = 0, red all 1, yellow/green all 0, emerg_active=0.
REQ-030 After reset release the first green is road 0, after ALLRED_TICKS ticks; reset mid-phase returns immediately to REQ-029 values.

Verification (NUM_ROADS=4, GREEN=4, YELLOW=2, ALLRED=1, tick_en=1 unless stated)
REQ-031 Reset, demand=4'hF -> road 0 green from cycle 1 for 4 cycles, yellow 2, all-red 1, road 1 green at cycle 8; rotation 0,1,2,3,0 period 28.
REQ-032 demand=4'b1001 from reset -> sequence road 0 -> road 3 -> road 0; roads 1,2 never leave red.
REQ-033 demand=4'b0001 -> road 0 green held >50 cycles; set demand[2]=1 -> yellow starts at next tick, road 2 green 3 cycles later.
REQ-034 Road 1 green at its 2nd cycle, emerg_req=1, emerg_road=3 -> yellow next cycle, road 3 green after 3 cycles, held while emerg_req=1; drop -> 4 more green cycles, then normal rotation.
REQ-035 tick_en every 4th cycle -> each state lasts 4x its tick count; reset asserted mid-YELLOW -> all red same cycle, road 0 green 1 tick after release.
REQ-036 Every cycle: one-hot lamp check per movement, at most one non-red road, never green->red without yellow except at reset.

Source files
------------

// File: rtl/traffic_phase_ctrl_if.sv
// rtl/traffic_phase_ctrl_if.sv - control inputs and lamp/status outputs of the intersection phase controller
interface traffic_phase_ctrl_if #(
  parameter int NUM_ROADS = 4
);
  localparam int RW = (NUM_ROADS > 1) ? $clog2(NUM_ROADS) : 1;

  logic                   tick_en;
  logic [NUM_ROADS-1:0]   demand;
  logic                   emerg_req;
  logic [RW-1:0]          emerg_road;
  logic [3*NUM_ROADS-1:0] red;
  logic [3*NUM_ROADS-1:0] yellow;
  logic [3*NUM_ROADS-1:0] green;
  logic [RW-1:0]          phase_road;
  logic [1:0]             phase_state;
  logic                   emerg_active;

  modport master (
    output tick_en, demand, emerg_req, emerg_road,
    input  red, yellow, green, phase_road, phase_state, emerg_active
  );

  modport slave (
    input  tick_en, demand, emerg_req, emerg_road,
    output red, yellow, green, phase_road, phase_state, emerg_active
  );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - one-road-at-a-time signal phase sequencer with emergency pre-emption
module traffic_phase_ctrl #(
  parameter int NUM_ROADS    = 4,
  parameter int GREEN_TICKS  = 20,
  parameter int YELLOW_TICKS = 5,
  parameter int ALLRED_TICKS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  traffic_phase_ctrl_if.slave  bus
);
  localparam int RW  = (NUM_ROADS > 1) ? $clog2(NUM_ROADS) : 1;
  localparam int RW1 = RW + 1;
  localparam int NL  = 3 * NUM_ROADS;

  localparam logic [15:0] GREEN_LD  = 16'(GREEN_TICKS - 1);
  localparam logic [15:0] YELLOW_LD = 16'(YELLOW_TICKS - 1);
  localparam logic [15:0] ALLRED_LD = 16'(ALLRED_TICKS - 1);

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'b00,
    ST_GREEN   = 2'b01,
    ST_YELLOW  = 2'b10
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [15:0]    r_timer, w_timer_nxt;
  logic [RW-1:0]  r_phase_road, w_phase_nxt;
  logic [RW-1:0]  r_next_road, w_next_nxt;
  logic           r_emerg_active, w_emerg_nxt;
  logic [NL-1:0]  r_red, r_yellow, r_green;
  logic [NL-1:0]  w_red_nxt, w_yellow_nxt, w_green_nxt;

  logic           w_emerg_valid;
  logic           w_timer_zero;
  logic           w_other_demand;
  logic [RW-1:0]  w_search_road;
  logic [RW-1:0]  w_entry_road;
  logic [RW:0]    w_sum;

  // Out-of-range emergency roads are treated as no request at all.
  assign w_emerg_valid = bus.emerg_req && ({1'b0, bus.emerg_road} < RW1'(NUM_ROADS));
  assign w_timer_zero  = (r_timer == 16'd0);
  // Road that the next GREEN will go to: an active emergency overrides the latched choice.
  assign w_entry_road  = w_emerg_valid ? bus.emerg_road : r_next_road;

  // Find the first demanding road after the current one, wrapping around.
  always_comb begin
    w_other_demand = 1'b0;
    w_search_road  = r_phase_road;
    w_sum          = '0;
    for (int i = 1; i < NUM_ROADS; i++) begin
      w_sum = {1'b0, r_phase_road} + RW1'(i);
      if (w_sum >= RW1'(NUM_ROADS)) w_sum = w_sum - RW1'(NUM_ROADS);
      if (!w_other_demand && bus.demand[w_sum[RW-1:0]]) begin
        w_other_demand = 1'b1;
        w_search_road  = w_sum[RW-1:0];
      end
    end
  end

  // Next-state logic; nothing moves except on timebase ticks.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_phase_nxt = r_phase_road;
    w_next_nxt  = r_next_road;
    w_emerg_nxt = r_emerg_active;
    if (bus.tick_en) begin
      unique case (r_state)
        ST_GREEN: begin
          if (w_emerg_valid) begin
            w_emerg_nxt = 1'b1;
            if (bus.emerg_road != r_phase_road) begin
              w_state_nxt = ST_YELLOW;
              w_timer_nxt = YELLOW_LD;
              w_next_nxt  = bus.emerg_road;
            end else if (!w_timer_zero) begin
              w_timer_nxt = r_timer - 16'd1;
            end
          end else if (r_emerg_active) begin
            // Emergency released while green: grant a fresh full green, then rotate.
            w_emerg_nxt = 1'b0;
            w_timer_nxt = GREEN_LD;
          end else if (!w_timer_zero) begin
            w_timer_nxt = r_timer - 16'd1;
          end else if (w_other_demand) begin
            w_state_nxt = ST_YELLOW;
            w_timer_nxt = YELLOW_LD;
            w_next_nxt  = w_search_road;
          end
        end
        ST_YELLOW: begin
          w_next_nxt = w_entry_road;
          if (w_emerg_valid) w_emerg_nxt = 1'b1;
          if (w_timer_zero) begin
            w_state_nxt = ST_ALL_RED;
            w_timer_nxt = ALLRED_LD;
          end else begin
            w_timer_nxt = r_timer - 16'd1;
          end
        end
        ST_ALL_RED: begin
          w_next_nxt = w_entry_road;
          if (w_emerg_valid) w_emerg_nxt = 1'b1;
          if (w_timer_zero) begin
            w_state_nxt = ST_GREEN;
            w_timer_nxt = GREEN_LD;
            w_phase_nxt = w_entry_road;
            w_emerg_nxt = w_emerg_valid;
          end else begin
            w_timer_nxt = r_timer - 16'd1;
          end
        end
        default: begin
          w_state_nxt = ST_ALL_RED;
          w_timer_nxt = ALLRED_LD;
        end
      endcase
    end
  end

  // Lamp pattern for the next state, so lamps register on the same edge as the state.
  always_comb begin
    w_red_nxt    = '1;
    w_yellow_nxt = '0;
    w_green_nxt  = '0;
    for (int k = 0; k < NUM_ROADS; k++) begin
      if (RW'(k) == w_phase_nxt) begin
        if (w_state_nxt == ST_GREEN) begin
          w_red_nxt[3*k +: 3]   = 3'b000;
          w_green_nxt[3*k +: 3] = 3'b111;
        end else if (w_state_nxt == ST_YELLOW) begin
          w_red_nxt[3*k +: 3]    = 3'b000;
          w_yellow_nxt[3*k +: 3] = 3'b111;
        end
      end
    end
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_ALL_RED;
      r_timer        <= ALLRED_LD;
      r_phase_road   <= RW'(NUM_ROADS - 1);
      r_next_road    <= '0;
      r_emerg_active <= 1'b0;
      r_red          <= '1;
      r_yellow       <= '0;
      r_green        <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_timer        <= w_timer_nxt;
      r_phase_road   <= w_phase_nxt;
      r_next_road    <= w_next_nxt;
      r_emerg_active <= w_emerg_nxt;
      r_red          <= w_red_nxt;
      r_yellow       <= w_yellow_nxt;
      r_green        <= w_green_nxt;
    end
  end

  assign bus.red          = r_red;
  assign bus.yellow       = r_yellow;
  assign bus.green        = r_green;
  assign bus.phase_road   = r_phase_road;
  assign bus.phase_state  = r_state;
  assign bus.emerg_active = r_emerg_active;
endmodule
